// File: rtl/dac_dem_pkg.sv
// Shared definitions for the DEM segment encoder: mode codes, direction type,
// dither LFSR geometry and modular pointer stepping.
package dac_dem_pkg;

  localparam logic [1:0] DEM_THERM = 2'b00;
  localparam logic [1:0] DEM_DWA   = 2'b01;
  localparam logic [1:0] DEM_BIDWA = 2'b10;

  typedef enum logic {DIR_FWD = 1'b0, DIR_BWD = 1'b1} dem_dir_t;

  // x^15 + x^14 + 1
  localparam int LFSR_W     = 15;
  localparam int LFSR_TAP_A = 14;
  localparam int LFSR_TAP_B = 13;

  // delta must lie in -n..n so a single correction keeps the result in 0..n-1
  function automatic int ptr_mod_step(input int ptr, input int delta, input int n);
    int s;
    s = ptr + delta;
    if (s >= n)
      s = s - n;
    else if (s < 0)
      s = s + n;
    return s;
  endfunction

endpackage

// File: rtl/dem_seg_encoder_param_if.sv
// Sample/result bundle between the quantiser side and the DEM segment encoder.
interface dem_seg_encoder_param_if #(
  parameter int N_ELEM = 18,
  parameter int IN_W   = 6
);
  localparam int PTR_W = $clog2(N_ELEM);

  logic              in_vld;
  logic [IN_W-1:0]   V;
  logic [1:0]        mode;
  logic              dith_en;
  logic              out_vld;
  logic [N_ELEM-1:0] SVout;
  logic [N_ELEM-1:0] STout;
  logic              sat_flg;
  logic [PTR_W-1:0]  ptr_dbg;

  modport master (output in_vld, V, mode, dith_en,
                  input  out_vld, SVout, STout, sat_flg, ptr_dbg);
  modport slave  (input  in_vld, V, mode, dith_en,
                  output out_vld, SVout, STout, sat_flg, ptr_dbg);
endinterface

// File: rtl/dem_rot_mask.sv
// Rotated run of k ones starting at ptr (fwd) or ending just below ptr (bwd),
// built as a 2*N_ELEM thermometer and folded back onto N_ELEM elements.
module dem_rot_mask
  import dac_dem_pkg::*;
#(
  parameter int N_ELEM = 18
) (
  input  logic [$clog2(N_ELEM)-1:0]   ptr,
  input  logic [$clog2(N_ELEM+1)-1:0] k,
  input  dem_dir_t                    dir,
  output logic [N_ELEM-1:0]           mask
);

  logic [2*N_ELEM-1:0] therm;
  logic [2*N_ELEM-1:0] dbl;
  int                  sh;

  // bwd run occupies ptr-k..ptr-1, shifted up by N_ELEM so the start stays non-negative
  always_comb begin
    sh    = (dir == DIR_FWD) ? int'(ptr) : int'(ptr) + N_ELEM - int'(k);
    therm = ~({(2*N_ELEM){1'b1}} << k);
    dbl   = therm << sh;
    mask  = dbl[N_ELEM-1:0] | dbl[2*N_ELEM-1:N_ELEM];
  end

endmodule

// File: rtl/dem_seg_encoder_param.sv
// Two-stage DEM encoder for one unary DAC segment (THERM / DWA / BIDWA).
// Pointer dither is built only when DEM_DITHER_EN is defined.
//   dir     | meaning
//   DIR_FWD | next BIDWA run grows upward from ptr
//   DIR_BWD | next BIDWA run grows downward from ptr-1
module dem_seg_encoder_param
  import dac_dem_pkg::*;
#(
  parameter int N_ELEM = 18,
  parameter int IN_W   = 6,
  parameter int SEED   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  dem_seg_encoder_param_if.slave  bus
);

  localparam int PTR_W = $clog2(N_ELEM);
  localparam int K_W   = $clog2(N_ELEM + 1);

  logic signed [IN_W:0] sum;
  int                   sum_i;
  logic [K_W-1:0]       k_clamp;
  logic                 sat_c;

  logic                 vld1;
  logic                 sat1;
  logic [K_W-1:0]       k1;
  logic [1:0]           mode1;

  logic [PTR_W-1:0]     ptr, ptr_nxt, mask_ptr;
  dem_dir_t             dir, dir_nxt, mask_dir;
  logic [N_ELEM-1:0]    mask;
  logic                 out_vld_q, sat_q;
  logic [N_ELEM-1:0]    sv_q, st_q;
  logic                 rotate;
  logic                 dith_step;
  int                   p;

  always_comb begin
    sum   = {bus.V[IN_W-1], bus.V} + (IN_W+1)'(N_ELEM / 2);
    sum_i = int'(sum);
    sat_c = 1'b0;
    k_clamp = K_W'(sum_i);
    if (sum_i < 0) begin
      k_clamp = '0;
      sat_c   = 1'b1;
    end else if (sum_i > N_ELEM) begin
      k_clamp = K_W'(N_ELEM);
      sat_c   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1  <= 1'b0;
      k1    <= '0;
      sat1  <= 1'b0;
      mode1 <= DEM_THERM;
    end else begin
      vld1 <= bus.in_vld;
      if (bus.in_vld) begin
        k1    <= k_clamp;
        sat1  <= sat_c;
        mode1 <= bus.mode;
      end
    end
  end

`ifdef DEM_DITHER_EN
  logic              dith1;
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      dith1 <= 1'b0;
      lfsr  <= LFSR_W'(SEED);
    end else begin
      if (bus.in_vld)
        dith1 <= bus.dith_en;
      if (vld1 && rotate)
        lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
    end
  end

  assign dith_step = dith1 & lfsr[0];
`else
  logic unused_dith;
  assign unused_dith = bus.dith_en;
  assign dith_step   = 1'b0;
`endif

  dem_rot_mask #(.N_ELEM(N_ELEM)) u_rot_mask (
    .ptr  (mask_ptr),
    .k    (k1),
    .dir  (mask_dir),
    .mask (mask)
  );

  always_comb begin
    rotate   = (mode1 != DEM_THERM);
    mask_ptr = rotate ? ptr : '0;
    mask_dir = (mode1 == DEM_BIDWA) ? dir : DIR_FWD;
    dir_nxt  = dir;
    ptr_nxt  = ptr;
    p        = int'(ptr);
    if (vld1 && rotate) begin
      // dither nudges the pointer for the next sample only; this sample's SV is unaffected
      if (mask_dir == DIR_FWD) begin
        p = ptr_mod_step(p, int'(k1), N_ELEM);
        p = ptr_mod_step(p, int'(dith_step), N_ELEM);
      end else begin
        p = ptr_mod_step(p, -int'(k1), N_ELEM);
        p = ptr_mod_step(p, -int'(dith_step), N_ELEM);
      end
      ptr_nxt = PTR_W'(p);
      if (mode1 == DEM_BIDWA)
        dir_nxt = (dir == DIR_FWD) ? DIR_BWD : DIR_FWD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      dir       <= DIR_FWD;
      out_vld_q <= 1'b0;
      sv_q      <= '0;
      st_q      <= '0;
      sat_q     <= 1'b0;
    end else begin
      out_vld_q <= vld1;
      if (vld1) begin
        ptr   <= ptr_nxt;
        dir   <= dir_nxt;
        sv_q  <= mask;
        st_q  <= mask ^ sv_q;
        sat_q <= sat1;
      end
    end
  end

  assign bus.out_vld = out_vld_q;
  assign bus.SVout   = sv_q;
  assign bus.STout   = st_q;
  assign bus.sat_flg = sat_q;
  assign bus.ptr_dbg = ptr;

endmodule
